// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised Moore sequence detector:
// state-width helper, default patterns, detection-mode and step encodings.
package seq_det_pkg;

    // Width needed to hold a prefix length in 0..pat_w.
    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Reset patterns for the common configurations; MSB is received first.
    localparam logic [3:0] DEFAULT_PAT_4 = 4'b1011;
    localparam logic [7:0] DEFAULT_PAT_8 = 8'b1101_0010;

    // Behaviour after a completed match.
    typedef enum logic {
        NON_OVERLAP = 1'b0,
        OVERLAP     = 1'b1
    } overlap_mode_e;

    // What the state register does on the coming edge.
    typedef enum logic [1:0] {
        STEP_HOLD    = 2'd0,  // no accepted bit
        STEP_LOAD    = 2'd1,  // new pattern, progress cleared
        STEP_ADVANCE = 2'd2,  // extend the current prefix with the new bit
        STEP_RESTART = 2'd3   // non-overlap after a match: start from empty history
    } step_e;

endpackage

// File: rtl/seq_prefix_next.sv
// Combinational KMP step: given the pattern, the current prefix-match length
// and the incoming bit, returns the longest pattern prefix that is a suffix
// of (matched prefix + bit). All candidate lengths are evaluated in parallel.
module seq_prefix_next
    import seq_det_pkg::*;
#(
    parameter int  PAT_W   = 4,
    localparam int STATE_W = state_w(PAT_W)
) (
    input  logic [PAT_W-1:0]   pattern,
    input  logic [STATE_W-1:0] state,
    input  logic               in,
    output logic [STATE_W-1:0] next_len
);

    logic cand_hit;

    // For the active state k, test every length j and keep the largest hit.
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        next_len = '0;
        cand_hit = 1'b0;
        for (int k = 0; k <= PAT_W; k++) begin
            if (state == STATE_W'(k)) begin
                // j may not exceed k+1 (string length) nor PAT_W (state range).
                for (int j = 1; j <= ((k < PAT_W) ? k + 1 : PAT_W); j++) begin
                    // Last bit of the candidate suffix is the incoming bit; it
                    // must equal pattern bit j-1 (pattern bit 0 is the MSB).
                    cand_hit = (in == pattern[PAT_W-j]);
                    // Remaining j-1 suffix bits come from the matched prefix,
                    // starting at prefix position k-j+1.
                    for (int m = 0; m < j - 1; m++) begin
                        cand_hit = cand_hit &
                                   (pattern[PAT_W-1-m] == pattern[PAT_W-1-(k-j+1+m)]);
                    end
                    // Ascending j: a later hit is always the longer one.
                    if (cand_hit) begin
                        next_len = STATE_W'(j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/seq_det_moore_param.sv
// Runtime-loadable Moore sequence detector with valid qualifier, selectable
// overlapping/non-overlapping detection, exposed prefix-match state and a
// saturating match counter.
module seq_det_moore_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = DEFAULT_PAT_4,
    parameter int               COUNT_W     = 8,
    localparam int              STATE_W     = state_w(PAT_W)
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic               in_valid,
    input  logic               in,
    input  logic               cfg_load,
    input  logic [PAT_W-1:0]   cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               det,
    output logic [STATE_W-1:0] match_state,
    output logic [COUNT_W-1:0] match_count
);

    localparam logic [STATE_W-1:0] FULL      = STATE_W'(PAT_W);
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [PAT_W-1:0]   pattern_q;
    logic [COUNT_W-1:0] count_q;
    logic [STATE_W-1:0] prefix_state;
    logic [STATE_W-1:0] prefix_next;
    step_e              step;
    logic               enter_full;

    // Single KMP evaluator; the non-overlap restart feeds it an empty history.
    seq_prefix_next #(
        .PAT_W (PAT_W)
    ) u_prefix_next (
        .pattern  (pattern_q),
        .state    (prefix_state),
        .in       (in),
        .next_len (prefix_next)
    );

    // Decide the step (load beats data), then select the next state.
    always_comb begin
        step         = STEP_HOLD;
        prefix_state = state_q;
        state_d      = state_q;
        enter_full   = 1'b0;

        if (cfg_load) begin
            step = STEP_LOAD;
        end else if (in_valid) begin
            if ((state_q == FULL) && (overlap_mode_e'(cfg_overlap) == NON_OVERLAP)) begin
                step = STEP_RESTART;
            end else begin
                step = STEP_ADVANCE;
            end
        end

        if (step == STEP_RESTART) begin
            prefix_state = '0;
        end

        // `in` only reaches state_d in the data steps, so an X on an
        // unqualified cycle never enters the register.
        unique case (step)
            STEP_HOLD:    state_d = state_q;
            STEP_LOAD:    state_d = '0;
            STEP_ADVANCE,
            STEP_RESTART: state_d = prefix_next;
            default:      state_d = state_q;
        endcase

        enter_full = ((step == STEP_ADVANCE) || (step == STEP_RESTART)) &&
                     (prefix_next == FULL);
    end

    // State and pattern registers; reset restores the default pattern.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= '0;
            pattern_q <= DEFAULT_PAT;
        end else begin
            state_q <= state_d;
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
            end
        end
    end

    // Saturating match counter; a clear wins over a simultaneous match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (cnt_clr) begin
            count_q <= '0;
        end else if (enter_full && (count_q != COUNT_MAX)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    // Moore outputs depend on registered state only.
    assign det         = (state_q == FULL);
    assign match_state = state_q;
    assign match_count = count_q;

endmodule
